// File: rtl/but_pkg.sv
// Shared types and sizing for the butterfly operand feeder: complex sample struct,
// feeder state encoding and the half-frame depth/index width.
package but_pkg;

    localparam int DATA_W = 8;
    localparam int N      = 16;
    localparam int HALF   = N / 2;
    localparam int IDX_W  = $clog2(HALF);

    typedef struct packed {
        logic signed [DATA_W-1:0] r;
        logic signed [DATA_W-1:0] i;
    } cplx_t;

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } feed_state_e;

endpackage

// File: rtl/but_pair_buf.sv
// Half-frame sample store: one write port, combinational read, shared address.
// Latency: write visible the cycle after; read 0 cycles. No backpressure.
module but_pair_buf
    import but_pkg::*;
#(
    parameter int DEPTH = HALF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  cplx_t                    wdat,
    output cplx_t                    rdat
);

    // Contents need no reset: every slot is rewritten in FILL before PAIR reads it.
    cplx_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdat;
        end
    end

    assign rdat = mem[addr];

endmodule

// File: rtl/but_pair_feeder.sv
// Pairs x[k] with x[k+N/2] for a radix-2 butterfly; pair valid 1 cycle after its second-half sample.
// Backpressure: one registered pair, in_ready drops in PAIR while it is held. Option: BUT_PAIR_FEEDER_FRAME_CHECK_EN.
module but_pair_feeder
    import but_pkg::*;
#(
    parameter int DATA_W = but_pkg::DATA_W,
    parameter int N      = but_pkg::N
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_r,
    input  logic signed [DATA_W-1:0]  in_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_r_0_8,
    output logic signed [DATA_W-1:0]  out_i_0_8,
    output logic signed [DATA_W-1:0]  out_r_8_16,
    output logic signed [DATA_W-1:0]  out_i_8_16,
    output logic [$clog2(N/2)-1:0]    out_idx
`ifdef BUT_PAIR_FEEDER_FRAME_CHECK_EN
    ,
    input  logic                      in_last,
    output logic                      frame_err
`endif
);

    localparam int                 HALF_N = N / 2;
    localparam int                 IW     = $clog2(HALF_N);
    localparam logic [IW-1:0]      LAST   = IW'(HALF_N - 1);

    feed_state_e   state;
    logic [IW-1:0] cnt;
    logic          take;
    logic          at_last;
    cplx_t         wr_dat;
    cplx_t         rd_dat;

    // FILL never stalls; PAIR stalls only while a previous pair is still held.
    assign in_ready = (state == FILL) || !out_valid || out_ready;
    assign take     = in_valid && in_ready;
    assign at_last  = (cnt == LAST);
    assign wr_dat   = {in_r, in_i};

    but_pair_buf #(
        .DEPTH(HALF_N)
    ) u_buf (
        .clk (clk),
        .we  (take && (state == FILL)),
        .addr(cnt),
        .wdat(wr_dat),
        .rdat(rd_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_r_0_8  <= '0;
            out_i_0_8  <= '0;
            out_r_8_16 <= '0;
            out_i_8_16 <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (take) begin
                // A new load overrides the clear above, so drain and reload can coincide.
                if (state == PAIR) begin
                    out_r_0_8  <= rd_dat.r;
                    out_i_0_8  <= rd_dat.i;
                    out_r_8_16 <= in_r;
                    out_i_8_16 <= in_i;
                    out_idx    <= cnt;
                    out_valid  <= 1'b1;
                end
                if (at_last) begin
                    cnt   <= '0;
                    state <= (state == FILL) ? PAIR : FILL;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef BUT_PAIR_FEEDER_FRAME_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else if (take && (in_last != ((state == PAIR) && at_last))) begin
            frame_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_but_pair_feeder.sv
// Directed bench for but_pair_feeder: ramp frames, back-to-back frames, stalls,
// extreme values, mid-frame reset and (optionally) the frame-marker check.
module tb_but_pair_feeder;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_r;
    logic signed [7:0] in_i;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_r_0_8;
    logic signed [7:0] out_i_0_8;
    logic signed [7:0] out_r_8_16;
    logic signed [7:0] out_i_8_16;
    logic [2:0]        out_idx;
    logic              in_last;
`ifdef BUT_PAIR_FEEDER_FRAME_CHECK_EN
    logic              frame_err;
`endif

    always #5 clk = ~clk;

    but_pair_feeder #(
        .DATA_W(8),
        .N     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r_0_8 (out_r_0_8),
        .out_i_0_8 (out_i_0_8),
        .out_r_8_16(out_r_8_16),
        .out_i_8_16(out_i_8_16),
        .out_idx   (out_idx)
`ifdef BUT_PAIR_FEEDER_FRAME_CHECK_EN
        ,
        .in_last   (in_last),
        .frame_err (frame_err)
`endif
    );

    typedef struct packed {
        logic signed [7:0] r0;
        logic signed [7:0] i0;
        logic signed [7:0] r8;
        logic signed [7:0] i8;
        logic [2:0]        idx;
    } pair_t;

    int                tests = 0;
    int                fails = 0;
    int                cyc   = 0;
    int                pairs = 0;
    pair_t             exp_q[$];
    logic signed [7:0] fr_r[16];
    logic signed [7:0] fr_i[16];
    logic              cur_last = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    // Output-side scoreboard: every accepted pair must match the next expected one.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            pairs++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pair", exp_q.size(), 1);
            end else begin
                pair_t p;
                p = exp_q.pop_front();
                chk("pair_idx", out_idx, p.idx);
                chk("pair_r0", out_r_0_8, p.r0);
                chk("pair_i0", out_i_0_8, p.i0);
                chk("pair_r8", out_r_8_16, p.r8);
                chk("pair_i8", out_i_8_16, p.i8);
            end
        end
    end

    task automatic push(input int k);
        exp_q.push_back({fr_r[k], fr_i[k], fr_r[k+8], fr_i[k+8], 3'(k)});
    endtask

    task automatic send(input logic signed [7:0] r, input logic signed [7:0] i);
        int w = 0;
        in_valid = 1'b1;
        in_r     = r;
        in_i     = i;
        in_last  = cur_last;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (w >= 50) chk("send_timeout", w, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Sends fr_r/fr_i as one frame; e0/e8 are the hand-computed reals of pair k=0.
    task automatic run_frame(input int e0, input int e8, input bit lat_chk);
        for (int j = 0; j < 16; j++) begin
            if (j >= 8) push(j - 8);
            cur_last = (j == 15);
            send(fr_r[j], fr_i[j]);
            if (lat_chk && j == 7) chk("lat_before", out_valid, 0);
            if (j == 8) begin
                chk("lat_valid", out_valid, 1);
                chk("first_idx", out_idx, 0);
                chk("first_r0", out_r_0_8, e0);
                chk("first_r8", out_r_8_16, e8);
            end
        end
        cur_last = 1'b0;
    endtask

    task automatic stall(input int n, input int r0, input int i0, input int r8, input int idx);
        out_ready = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_r0", out_r_0_8, r0);
            chk("stall_i0", out_i_0_8, i0);
            chk("stall_r8", out_r_8_16, r8);
            chk("stall_idx", out_idx, idx);
        end
        out_ready = 1'b1;
    endtask

    task automatic drain(input string tag);
        @(posedge clk);
        #1;
        chk(tag, exp_q.size(), 0);
        chk({tag, "_valid"}, out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int p0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_r      = '0;
        in_i      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_idx", out_idx, 0);
        chk("rst_r0", out_r_0_8, 0);
        chk("rst_i8", out_i_8_16, 0);
        rst = 1'b0;

        // Ramp r=0..15, i=-r.
        for (int j = 0; j < 16; j++) begin
            fr_r[j] = 8'(j);
            fr_i[j] = 8'(-j);
        end
        p0 = pairs;
        run_frame(0, 8, 1'b1);
        drain("ramp_drain");
        chk("ramp_pairs", pairs - p0, 8);

        // Two frames back to back, no bubbles.
        c0 = cyc;
        p0 = pairs;
        run_frame(0, 8, 1'b0);
        for (int j = 0; j < 16; j++) begin
            fr_r[j] = 8'(100 + j);
            fr_i[j] = 8'(-(100 + j));
        end
        run_frame(100, 108, 1'b0);
        chk("b2b_cycles", cyc - c0, 32);
        drain("b2b_drain");
        chk("b2b_pairs", pairs - p0, 16);

        // Backpressure while pairs k=2 and k=4 are held.
        for (int j = 0; j < 16; j++) begin
            fr_r[j] = 8'(20 + j);
            fr_i[j] = 8'(j);
        end
        p0 = pairs;
        for (int j = 0; j < 16; j++) begin
            if (j >= 8) push(j - 8);
            cur_last = (j == 15);
            send(fr_r[j], fr_i[j]);
            if (j == 10) stall(3, 22, 2, 30, 2);
            if (j == 12) stall(2, 24, 4, 32, 4);
        end
        cur_last = 1'b0;
        drain("bp_drain");
        chk("bp_pairs", pairs - p0, 8);

        // Extreme values pass bit-exact.
        for (int j = 0; j < 16; j++) begin
            fr_r[j] = (j % 2 == 0) ? -8'sd128 : 8'sd127;
            fr_i[j] = (j % 2 == 0) ? 8'sd127 : -8'sd128;
        end
        run_frame(-128, -128, 1'b0);
        drain("ext_drain");

        // Reset mid-frame with pair k=3 still pending.
        for (int j = 0; j < 16; j++) begin
            fr_r[j] = 8'(40 + j);
            fr_i[j] = 8'(1 + j);
        end
        for (int j = 0; j < 12; j++) begin
            if (j >= 8 && j < 11) push(j - 8);
            send(fr_r[j], fr_i[j]);
        end
        chk("pre_rst_valid", out_valid, 1);
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_idx", out_idx, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_r0", out_r_0_8, 0);
        chk("mid_rst_q", exp_q.size(), 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            fr_r[j] = 8'(60 + j);
            fr_i[j] = 8'(-60 - j);
        end
        p0 = pairs;
        run_frame(60, 68, 1'b0);
        drain("post_rst_drain");
        chk("post_rst_pairs", pairs - p0, 8);

`ifdef BUT_PAIR_FEEDER_FRAME_CHECK_EN
        chk("ferr_clean", frame_err, 0);
        for (int j = 0; j < 16; j++) begin
            fr_r[j] = 8'(j - 8);
            fr_i[j] = 8'(3 * j);
        end
        for (int j = 0; j < 16; j++) begin
            if (j >= 8) push(j - 8);
            cur_last = (j == 14);
            send(fr_r[j], fr_i[j]);
            if (j == 13) chk("ferr_before", frame_err, 0);
            if (j == 14) chk("ferr_set", frame_err, 1);
        end
        cur_last = 1'b0;
        drain("ferr_drain");
        chk("ferr_sticky", frame_err, 1);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("final_queue", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/but_pair_feeder.md
# but_pair_feeder

Streaming front end for a radix-2 butterfly stage. It accepts one complex sample per handshake, holds the first half of each N-point frame, then pairs each second-half sample x[k+N/2] with its stored partner x[k]. Each pair is presented on a registered valid/ready output that drives the `_0_8` / `_8_16` operand inputs of the complex butterfly. It is the producer side of the butterfly operand interface: it sits between the sample source and the butterfly.

## Interface
- `DATA_W`, 8: signed width of each real/imag component.
- `N`, 16: frame length; power of two, ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block can accept a sample.
- `in_r`, `in_i`  in  DATA_W  signed sample, real/imag.
- `out_valid`  out  1  pair valid.
- `out_ready`  in  1  butterfly accepts pair.
- `out_r_0_8`, `out_i_0_8`  out  DATA_W  first-half sample x[k].
- `out_r_8_16`, `out_i_8_16`  out  DATA_W  second-half sample x[k+N/2].
- `out_idx`  out  $clog2(N/2)  pair index k.

## Operation
- Input handshake: `in_valid && in_ready`. Output handshake: `out_valid && out_ready`.
- The FSM has two states, FILL and PAIR. Counter `cnt` runs 0..N/2-1.
- **FILL**
  - `in_ready` = 1.
  - Each input handshake writes `buf[cnt]`.
  - At cnt = N/2-1: go to PAIR and set cnt = 0.
- **PAIR**
  - `in_ready` = `!out_valid || out_ready`.
  - Each input handshake loads the output register with {`buf[cnt]`, input sample} and `out_idx` = cnt, and sets `out_valid` = 1.
  - At cnt = N/2-1: go to FILL and set cnt = 0.
- `out_valid` clears on an output handshake with no new load in the same cycle.
- A simultaneous output handshake and new load is allowed; the register takes the new pair and `out_valid` stays 1.
- Output fields hold their values while `out_valid && !out_ready`.
- Frames run back to back. After the last PAIR input, the next cycle is FILL and accepts immediately. The pending last pair drains concurrently.
- No arithmetic is performed; samples pass bit-exact. Pairs are emitted in k order 0..N/2-1.

## Timing
- Reset values:
  - State FILL, cnt 0.
  - `out_valid` 0, `out_idx` 0, all output data 0.
  - `in_ready` 1.
  - Buffer contents are don't-care.
- Latency: a pair is valid the cycle after the handshake of its second-half sample.
- Throughput is 1 sample/cycle with `out_ready` held high. That gives N input cycles per frame and N/2 pairs per frame.
- Backpressure: with `out_ready` low in PAIR, at most one pair is held and `in_ready` drops the cycle after the load.
- Reset mid-frame discards the partial frame and any pending pair. `out_valid` is 0 the cycle after `rst`.
- `in_valid` low in either state: no state change.

## Configuration
- Macro: `BUT_PAIR_FEEDER_FRAME_CHECK_EN`.
- **Defined**
  - Adds input `in_last` (1 bit) and output `frame_err` (1 bit, sticky, reset 0).
  - `frame_err` sets the cycle after an input handshake where `in_last` ≠ (state==PAIR && cnt==N/2-1).
  - Data flow is unaffected; only `rst` clears the flag.
- **Undefined**: neither port exists, and there is no check logic.

## Structure
- Shared package `but_pkg` holds:
  - the `cplx_t` packed struct {r, i} parameterised via `DATA_W` localparam;
  - the state enum `feed_state_e` {FILL, PAIR};
  - the `HALF = N/2` and `IDX_W` constants.
- Sub-module `but_pair_buf`: HALF-deep `cplx_t` register array with one write port and a combinational read port, both addressed by cnt.

## Test plan
- N=16, ramp input r=0..15, i=-r, `out_ready`=1 → pairs k=0..7 are {(k,-k),(k+8,-k-8)}; first `out_valid` appears 1 cycle after input #8; 8 pairs per frame.
- Two frames back to back (second frame r=100..115) → 16 pairs with no bubbles; the second frame's k=0 pair is (100,108).
- `out_ready`=0 during pairs k=2..4 → outputs hold (2,10), `in_ready` drops, no sample is lost or duplicated, order is preserved.
- Input extremes r=-128/127 and i=127/-128 → output is bit-exact, with no sign or width change.
- `rst` asserted after input #11 → `out_valid`=0 next cycle; the next 16 samples form a clean frame starting at k=0.
- With `BUT_PAIR_FEEDER_FRAME_CHECK_EN`: `in_last` on sample #14 → `frame_err`=1 the next cycle and stays 1; data pairs are unchanged.
